hilo_muldiv_unit: RTL and testbench

//  Multi-cycle multiply/divide unit that owns the HI/LO register pair for the MIPS pipeline.

---
 rtl/hilo_muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with an iterative multiply/divide engine for the EX stage.
// Shift-add multiply and restoring divide share one 2*WIDTH accumulator.
module hilo_muldiv_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             divzero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;
  localparam logic [2:0] OpMadd  = 3'b110;
  localparam logic [2:0] OpMsub  = 3'b111;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic             in_div, in_signed;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign in_div    = (op_i == OpDiv) || (op_i == OpDivu);
  assign in_signed = !((op_i == OpMultu) || (op_i == OpDivu));
  assign a_mag     = (in_signed && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag     = (in_signed && b_i[WIDTH-1]) ? -b_i : b_i;

  logic               q_is_div;
  logic [WIDTH:0]     mul_sum, div_trial, div_diff;
  logic [2*WIDTH-1:0] mul_step, div_step, fast_prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  assign q_is_div = (op_q == OpDiv) || (op_q == OpDivu);

  // Multiply: acc = {partial, multiplier}; add opa into the upper half, then shift right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; trial-subtract the divisor each step.
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_trial - {1'b0, opa_q};
  assign div_step  = div_diff[WIDTH] ? {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign fast_prod = {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} * {{WIDTH{1'b0}}, opa_q};

  assign prod_s = neg_q ? -acc_q : acc_q;
  assign quo_s  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_s  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    opa_d     = opa_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i && !cancel_i) begin
          if (op_i == OpMthi) begin
            hi_d = a_i;
          end else if (op_i == OpMtlo) begin
            lo_d = a_i;
          end else if (in_div && (b_i == '0)) begin
            dz_d = 1'b1;
          end else begin
            op_d      = op_i;
            opa_d     = in_div ? b_mag : a_mag;
            acc_d     = in_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            neg_d     = in_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            rem_neg_d = in_signed && a_i[WIDTH-1];
            cnt_d     = (FAST_MUL && !in_div) ? '0 : CntW'(WIDTH - 1);
            state_d   = StCalc;
          end
        end
      end
      StCalc: begin
        if (cancel_i) begin
          state_d = StIdle;
        end else begin
          acc_d = q_is_div ? div_step : (FAST_MUL ? fast_prod : mul_step);
          if (cnt_q == '0) begin
            state_d = StFix;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!cancel_i) begin
          done_d = 1'b1;
          case (op_q)
            OpMult, OpMultu: {hi_d, lo_d} = prod_s;
            OpMadd:          {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
            OpMsub:          {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
            OpDiv, OpDivu: begin
              lo_d = quo_s;
              hi_d = rem_s;
            end
            default: ;
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= '0;
      opa_q     <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      opa_q     <= opa_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy_o    = (state_q != StIdle);
  assign done_o    = done_q;
  assign divzero_o = dz_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized and directed checks of hilo_muldiv_unit against an arithmetic HI/LO model.
module tb_hilo_muldiv_unit;

  localparam int unsigned W = 32;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;
  localparam logic [2:0] OpMadd  = 3'b110;
  localparam logic [2:0] OpMsub  = 3'b111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, cancel, fstart, fcancel;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, dz, fbusy, fdone, fdz;
  logic [W-1:0] hi, lo, fhi, flo;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] hi_m, lo_m;

  hilo_muldiv_unit #(.WIDTH(W), .FAST_MUL(1'b0)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b), .cancel_i(cancel),
    .busy_o(busy), .done_o(done), .divzero_o(dz), .hi_o(hi), .lo_o(lo)
  );

  hilo_muldiv_unit #(.WIDTH(W), .FAST_MUL(1'b1)) dut_fast (
    .clk(clk), .rst(rst), .start_i(fstart), .op_i(op), .a_i(a), .b_i(b), .cancel_i(fcancel),
    .busy_o(fbusy), .done_o(fdone), .divzero_o(fdz), .hi_o(fhi), .lo_o(flo)
  );

  // Architectural effect of one instruction on HI/LO, from plain 64-bit arithmetic.
  task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] h_in, input logic [W-1:0] l_in,
                       output logic [W-1:0] h_out, output logic [W-1:0] l_out, output bit z);
    longint sx, sy, q, r;
    logic [63:0] p, ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    z = 1'b0;
    h_out = h_in;
    l_out = l_in;
    case (o)
      OpMult:  begin p = sx * sy; {h_out, l_out} = p; end
      OpMultu: begin p = ux * uy; {h_out, l_out} = p; end
      OpDiv: begin
        if (y == 0) z = 1'b1;
        else begin
          q = sx / sy; r = sx % sy;
          p = q; l_out = p[31:0];
          p = r; h_out = p[31:0];
        end
      end
      OpDivu: begin
        if (y == 0) z = 1'b1;
        else begin l_out = x / y; h_out = x % y; end
      end
      OpMthi: h_out = x;
      OpMtlo: l_out = x;
      OpMadd: begin p = {h_in, l_in} + 64'(sx * sy); {h_out, l_out} = p; end
      default: begin p = {h_in, l_in} - 64'(sx * sy); {h_out, l_out} = p; end
    endcase
  endtask

  // Issue one instruction and observe it cycle by cycle (cycle 1 follows the issuing edge).
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int done_cyc, output int dz_cyc, output int busy_last,
                        output bit both, output bit moved);
    logic [W-1:0] h0, l0;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    h0 = hi; l0 = lo;
    done_cyc = -1; dz_cyc = -1; busy_last = 0; both = 1'b0; moved = 1'b0;
    for (int c = 1; c <= W + 8; c++) begin
      if (busy) busy_last = c;
      if (done && done_cyc < 0) done_cyc = c;
      if (dz && dz_cyc < 0) dz_cyc = c;
      if (done && dz) both = 1'b1;
      if (busy && (hi !== h0 || lo !== l0)) moved = 1'b1;
      if (!busy && c >= 2) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cancel = 1'b0; fstart = 1'b0; fcancel = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    hi_m = '0; lo_m = '0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0 || dz !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses got done=%b dz=%b want 0 0", done, dz); end
    n_tests++; if ({hi, lo} !== 64'h0) begin
      n_fail++; $display("FAIL reset_hilo got %h_%h want 0_0", hi, lo); end
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [10] = '{OpMultu, OpMult, OpDiv, OpDivu, OpDiv, OpDivu,
                               OpMthi, OpMtlo, OpMadd, OpMsub};
    logic [31:0] t_a [10] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd7, 32'h80000000,
                              32'd64, 32'h0, 32'hFFFFFFFF, 32'd1, 32'd2};
    logic [31:0] t_b [10] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd7,
                              32'h0, 32'h0, 32'd1, 32'd1};
    logic [63:0] t_x [10] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFEB,
                              64'hFFFFFFFF_FFFFFFFD, 64'hFFFFFFFF_FFFFFFFD,
                              64'h00000000_80000000, 64'h00000001_00000009,
                              64'h00000000_00000009, 64'h00000000_FFFFFFFF,
                              64'h00000001_00000000, 64'h00000000_FFFFFFFE};
    int dc, zc, bl; bit both, moved, isz, ismt;
    for (int i = 0; i < 10; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], dc, zc, bl, both, moved);
      isz  = (t_op[i] == OpDiv || t_op[i] == OpDivu) && t_b[i] == 0;
      ismt = (t_op[i] == OpMthi || t_op[i] == OpMtlo);
      n_tests++; if ({hi, lo} !== t_x[i]) begin
        n_fail++; $display("FAIL dir%0d_hilo got %h_%h want %h", i, hi, lo, t_x[i]); end
      n_tests++; if (dc != ((isz || ismt) ? -1 : int'(W) + 2) || zc != (isz ? 1 : -1)) begin
        n_fail++; $display("FAIL dir%0d_timing got done@%0d dz@%0d", i, dc, zc); end
      n_tests++; if (bl != ((isz || ismt) ? 0 : int'(W) + 1) || both || moved) begin
        n_fail++; $display("FAIL dir%0d_busy got last_busy=%0d both=%b moved=%b", i, bl, both, moved);
      end
      {hi_m, lo_m} = t_x[i];
    end
  endtask

  task automatic test_fast_mul();
    logic [31:0] t_a [2] = '{32'hFFFFFFFD, 32'hFFFFFFFF};
    logic [31:0] t_b [2] = '{32'd7, 32'hFFFFFFFF};
    logic [2:0]  t_op [2] = '{OpMult, OpMultu};
    logic [63:0] t_x [2] = '{64'hFFFFFFFF_FFFFFFEB, 64'hFFFFFFFE_00000001};
    int fc;
    for (int i = 0; i < 2; i++) begin
      op = t_op[i]; a = t_a[i]; b = t_b[i]; fstart = 1'b1;
      @(posedge clk); #1;
      fstart = 1'b0;
      fc = -1;
      for (int c = 1; c <= 10; c++) begin
        if (fdone && fc < 0) fc = c;
        if (fc > 0) break;
        @(posedge clk); #1;
      end
      n_tests++; if (fc != 3) begin n_fail++; $display("FAIL fast%0d_done got %0d want 3", i, fc); end
      n_tests++; if ({fhi, flo} !== t_x[i]) begin
        n_fail++; $display("FAIL fast%0d_hilo got %h_%h want %h", i, fhi, flo, t_x[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [2:0] o; logic [W-1:0] x, y, he, le; bit z, mt;
    int dc, zc, bl; bit both, moved;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom();
      case ($urandom_range(0, 3))
        0: y = W'($urandom_range(0, 15));
        1: y = (i % 2 == 0) ? 32'hFFFFFFFF : 32'h80000000;
        default: y = $urandom();
      endcase
      if ($urandom_range(0, 5) == 0) x = 32'h80000000;
      model(o, x, y, hi_m, lo_m, he, le, z);
      mt = (o == OpMthi || o == OpMtlo);
      run_op(o, x, y, dc, zc, bl, both, moved);
      n_tests++; if ({hi, lo} !== {he, le}) begin
        n_fail++; $display("FAIL rnd%0d_hilo op=%0d a=%h b=%h got %h_%h want %h_%h",
                           i, o, x, y, hi, lo, he, le); end
      n_tests++; if (dc != ((z || mt) ? -1 : int'(W) + 2) || zc != (z ? 1 : -1) || both || moved) begin
        n_fail++; $display("FAIL rnd%0d_ctrl op=%0d got done@%0d dz@%0d both=%b moved=%b",
                           i, o, dc, zc, both, moved); end
      hi_m = he; lo_m = le;
    end
  endtask

  task automatic test_busy_ignore();
    logic [W-1:0] he, le; bit z; int dc;
    op = OpMultu; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
    model(OpMultu, a, b, hi_m, lo_m, he, le, z);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 op = OpMthi; a = 32'hDEADBEEF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = OpDivu; b = 32'h0;
    dc = -1;
    for (int c = 4; c <= W + 8; c++) begin
      if (done) begin dc = c; break; end
      @(posedge clk); #1;
    end
    n_tests++; if (dc != int'(W) + 2) begin
      n_fail++; $display("FAIL busy_ignore_done got %0d want %0d", dc, W + 2); end
    n_tests++; if ({hi, lo} !== {he, le}) begin
      n_fail++; $display("FAIL busy_ignore_hilo got %h_%h want %h_%h", hi, lo, he, le); end
    hi_m = he; lo_m = le;
    @(posedge clk); #1;
  endtask

  task automatic test_cancel();
    int cut [2] = '{10, W + 1};
    bit seen;
    for (int k = 0; k < 2; k++) begin
      op = OpDivu; a = $urandom(); b = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (cut[k] - 1) @(posedge clk);
      #1 cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      n_tests++; if (busy !== 1'b0) begin
        n_fail++; $display("FAIL cancel%0d_busy got %b want 0", k, busy); end
      seen = 1'b0;
      for (int c = 0; c < W + 4; c++) begin
        if (done) seen = 1'b1;
        @(posedge clk); #1;
      end
      n_tests++; if (seen || {hi, lo} !== {hi_m, lo_m}) begin
        n_fail++; $display("FAIL cancel%0d_effect done_seen=%b got %h_%h want %h_%h",
                           k, seen, hi, lo, hi_m, lo_m); end
    end
    // start together with cancel in IDLE must do nothing, including divide-by-zero and MTHI.
    for (int k = 0; k < 3; k++) begin
      op = (k == 0) ? OpMult : ((k == 1) ? OpDivu : OpMthi);
      a = 32'hCAFE_0000; b = (k == 1) ? 32'h0 : 32'd5;
      start = 1'b1; cancel = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (busy || done || dz) seen = 1'b1;
        @(posedge clk); #1;
      end
      n_tests++; if (seen || {hi, lo} !== {hi_m, lo_m}) begin
        n_fail++; $display("FAIL start_cancel%0d activity=%b got %h_%h want %h_%h",
                           k, seen, hi, lo, hi_m, lo_m); end
    end
  endtask

  task automatic test_reset_mid();
    int dc, zc, bl; bit both, moved;
    run_op(OpMthi, 32'h1234_5678, 32'h0, dc, zc, bl, both, moved);
    op = OpMult; a = 32'hFFFF_0001; b = 32'h0000_7777; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    hi_m = '0; lo_m = '0;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0 || {hi, lo} !== 64'h0) begin
      n_fail++; $display("FAIL reset_mid got busy=%b done=%b dz=%b hilo=%h_%h want 0 0 0 0_0",
                         busy, done, dz, hi, lo); end
    dc = 0;
    for (int c = 0; c < W + 4; c++) begin
      if (done) dc = 1;
      @(posedge clk); #1;
    end
    n_tests++; if (dc != 0 || {hi, lo} !== 64'h0) begin
      n_fail++; $display("FAIL reset_mid_after done_seen=%0d got %h_%h want 0_0", dc, hi, lo); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_fast_mul();
    test_random();
    test_busy_ignore();
    test_cancel();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
